// File: rtl/axi_arb_pkg.sv
// Shared definitions for the AXI read/write channel arbiters.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  localparam logic [1:0] FIXED = 2'b00;
  localparam logic [1:0] INCR  = 2'b01;
  localparam logic [1:0] WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/rr_arb2.sv
// Two-way request picker: round-robin against the last grant, or fixed priority
// to requester 0 when rr_en_i is low.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  input  logic       rr_en_i,
  output logic       gnt_o
);

  always_comb begin
    gnt_o = 1'b0;
    if (req_i == 2'b11) begin
      gnt_o = rr_en_i ? ~last_i : 1'b0;
    end else if (req_i[1]) begin
      gnt_o = 1'b1;
    end
  end

endmodule

// File: rtl/axi_rd_arb2.sv
// Two-master AXI4 read arbiter with a single outstanding burst, burst-length
// and ID checking, and a sticky protocol error flag.
module axi_rd_arb2
  import axi_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4,
  parameter int DATA_W = 32,
  parameter bit RR     = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_arvalid_i,
  input  logic [ADDR_W-1:0] m0_araddr_i,
  input  logic [ID_W-1:0]   m0_arid_i,
  input  logic [7:0]        m0_arlen_i,
  input  logic [1:0]        m0_arburst_i,
  output logic              m0_arready_o,
  output logic              m0_rvalid_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  output logic [1:0]        m0_rresp_o,
  output logic [ID_W-1:0]   m0_rid_o,
  output logic              m0_rlast_o,
  input  logic              m0_rready_i,
  input  logic              m1_arvalid_i,
  input  logic [ADDR_W-1:0] m1_araddr_i,
  input  logic [ID_W-1:0]   m1_arid_i,
  input  logic [7:0]        m1_arlen_i,
  input  logic [1:0]        m1_arburst_i,
  output logic              m1_arready_o,
  output logic              m1_rvalid_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic [1:0]        m1_rresp_o,
  output logic [ID_W-1:0]   m1_rid_o,
  output logic              m1_rlast_o,
  input  logic              m1_rready_i,
  output logic              s_arvalid_o,
  output logic [ADDR_W-1:0] s_araddr_o,
  output logic [ID_W-1:0]   s_arid_o,
  output logic [7:0]        s_arlen_o,
  output logic [1:0]        s_arburst_o,
  input  logic              s_arready_i,
  input  logic              s_rvalid_i,
  input  logic [DATA_W-1:0] s_rdata_i,
  input  logic [1:0]        s_rresp_i,
  input  logic [ID_W-1:0]   s_rid_i,
  input  logic              s_rlast_i,
  output logic              s_rready_o,
  output logic              grant_o,
  output logic              busy_o,
  output logic              err_o
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [7:0]        len_q, len_d;
  logic [1:0]        burst_q, burst_d;
  logic              grant_q, grant_d;
  logic [8:0]        beat_q, beat_d;
  logic              err_q, err_d;

  logic [1:0] req;
  logic       win;
  logic       sel_rready;
  logic       r_beat;

  assign req        = {m1_arvalid_i, m0_arvalid_i};
  assign sel_rready = grant_q ? m1_rready_i : m0_rready_i;
  assign r_beat     = (state_q == DATA) && s_rvalid_i && sel_rready;

  rr_arb2 u_pick (
    .req_i   (req),
    .last_i  (grant_q),
    .rr_en_i (RR),
    .gnt_o   (win)
  );

  // grant_q doubles as last_grant; resetting it to 1 lets master 0 win the first tie.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      id_q    <= '0;
      len_q   <= '0;
      burst_q <= '0;
      grant_q <= 1'b1;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      id_q    <= id_d;
      len_q   <= len_d;
      burst_q <= burst_d;
      grant_q <= grant_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    id_d    = id_q;
    len_d   = len_q;
    burst_d = burst_q;
    grant_d = grant_q;
    beat_d  = beat_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (s_rvalid_i) err_d = 1'b1;
        if (req != 2'b00) begin
          addr_d  = win ? m1_araddr_i  : m0_araddr_i;
          id_d    = win ? m1_arid_i    : m0_arid_i;
          len_d   = win ? m1_arlen_i   : m0_arlen_i;
          burst_d = win ? m1_arburst_i : m0_arburst_i;
          grant_d = win;
          beat_d  = '0;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (s_arready_i) state_d = DATA;
      end
      DATA: begin
        if (r_beat) begin
          beat_d = beat_q + 9'd1;
          // beat_q is 0-based, so a correct last beat arrives with beat_q == arlen.
          if (s_rlast_i) begin
            if ((beat_q != {1'b0, len_q}) || (s_rid_i != id_q)) err_d = 1'b1;
            state_d = IDLE;
          end else if (beat_q == {1'b0, len_q}) begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m0_arready_o = 1'b0;
    m1_arready_o = 1'b0;
    s_arvalid_o  = 1'b0;
    m0_rvalid_o  = 1'b0;
    m1_rvalid_o  = 1'b0;
    s_rready_o   = 1'b0;
    case (state_q)
      IDLE: begin
        m0_arready_o = (req != 2'b00) && !win;
        m1_arready_o = (req != 2'b00) && win;
      end
      ADDR: s_arvalid_o = 1'b1;
      DATA: begin
        m0_rvalid_o = s_rvalid_i && !grant_q;
        m1_rvalid_o = s_rvalid_i && grant_q;
        s_rready_o  = sel_rready;
      end
      default: ;
    endcase
  end

  assign s_araddr_o  = addr_q;
  assign s_arid_o    = id_q;
  assign s_arlen_o   = len_q;
  assign s_arburst_o = burst_q;

  assign m0_rdata_o = s_rdata_i;
  assign m0_rresp_o = s_rresp_i;
  assign m0_rid_o   = s_rid_i;
  assign m0_rlast_o = s_rlast_i;
  assign m1_rdata_o = s_rdata_i;
  assign m1_rresp_o = s_rresp_i;
  assign m1_rid_o   = s_rid_i;
  assign m1_rlast_o = s_rlast_i;

  assign grant_o = grant_q;
  assign busy_o  = (state_q != IDLE);
  assign err_o   = err_q;

endmodule

// File: tb/tb_axi_rd_arb2.sv
// Directed bench for axi_rd_arb2: a round-robin instance and a fixed-priority
// instance share all inputs and run in lockstep.
module tb_axi_rd_arb2;
  import axi_arb_pkg::*;

  localparam logic [31:0] M0_ADDR = 32'h0000_0100;
  localparam logic [31:0] M1_ADDR = 32'h0000_2000;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  logic        m0_arvalid, m1_arvalid, m0_rready, m1_rready;
  logic [31:0] m0_araddr, m1_araddr;
  logic [3:0]  m0_arid, m1_arid;
  logic [7:0]  m0_arlen, m1_arlen;
  logic [1:0]  m0_arburst, m1_arburst;
  logic        s_arready, s_rvalid, s_rlast;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic [3:0]  s_rid;

  logic        m0_arready, m0_rvalid, m0_rlast, m1_arready, m1_rvalid, m1_rlast;
  logic [31:0] m0_rdata, m1_rdata, s_araddr;
  logic [1:0]  m0_rresp, m1_rresp, s_arburst;
  logic [3:0]  m0_rid, m1_rid, s_arid;
  logic [7:0]  s_arlen;
  logic        s_arvalid, s_rready, grant, busy, err;

  logic        fp_m0_arready, fp_m0_rvalid, fp_m0_rlast, fp_m1_arready, fp_m1_rvalid, fp_m1_rlast;
  logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_s_araddr;
  logic [1:0]  fp_m0_rresp, fp_m1_rresp, fp_s_arburst;
  logic [3:0]  fp_m0_rid, fp_m1_rid, fp_s_arid;
  logic [7:0]  fp_s_arlen;
  logic        fp_s_arvalid, fp_s_rready, fp_grant, fp_busy, fp_err;

  axi_rd_arb2 #(.RR(1'b1)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_arvalid_i(m0_arvalid), .m0_araddr_i(m0_araddr), .m0_arid_i(m0_arid),
    .m0_arlen_i(m0_arlen), .m0_arburst_i(m0_arburst), .m0_arready_o(m0_arready),
    .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata), .m0_rresp_o(m0_rresp),
    .m0_rid_o(m0_rid), .m0_rlast_o(m0_rlast), .m0_rready_i(m0_rready),
    .m1_arvalid_i(m1_arvalid), .m1_araddr_i(m1_araddr), .m1_arid_i(m1_arid),
    .m1_arlen_i(m1_arlen), .m1_arburst_i(m1_arburst), .m1_arready_o(m1_arready),
    .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata), .m1_rresp_o(m1_rresp),
    .m1_rid_o(m1_rid), .m1_rlast_o(m1_rlast), .m1_rready_i(m1_rready),
    .s_arvalid_o(s_arvalid), .s_araddr_o(s_araddr), .s_arid_o(s_arid),
    .s_arlen_o(s_arlen), .s_arburst_o(s_arburst), .s_arready_i(s_arready),
    .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata), .s_rresp_i(s_rresp),
    .s_rid_i(s_rid), .s_rlast_i(s_rlast), .s_rready_o(s_rready),
    .grant_o(grant), .busy_o(busy), .err_o(err)
  );

  axi_rd_arb2 #(.RR(1'b0)) dut_fp (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_arvalid_i(m0_arvalid), .m0_araddr_i(m0_araddr), .m0_arid_i(m0_arid),
    .m0_arlen_i(m0_arlen), .m0_arburst_i(m0_arburst), .m0_arready_o(fp_m0_arready),
    .m0_rvalid_o(fp_m0_rvalid), .m0_rdata_o(fp_m0_rdata), .m0_rresp_o(fp_m0_rresp),
    .m0_rid_o(fp_m0_rid), .m0_rlast_o(fp_m0_rlast), .m0_rready_i(m0_rready),
    .m1_arvalid_i(m1_arvalid), .m1_araddr_i(m1_araddr), .m1_arid_i(m1_arid),
    .m1_arlen_i(m1_arlen), .m1_arburst_i(m1_arburst), .m1_arready_o(fp_m1_arready),
    .m1_rvalid_o(fp_m1_rvalid), .m1_rdata_o(fp_m1_rdata), .m1_rresp_o(fp_m1_rresp),
    .m1_rid_o(fp_m1_rid), .m1_rlast_o(fp_m1_rlast), .m1_rready_i(m1_rready),
    .s_arvalid_o(fp_s_arvalid), .s_araddr_o(fp_s_araddr), .s_arid_o(fp_s_arid),
    .s_arlen_o(fp_s_arlen), .s_arburst_o(fp_s_arburst), .s_arready_i(s_arready),
    .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata), .s_rresp_i(s_rresp),
    .s_rid_i(s_rid), .s_rlast_i(s_rlast), .s_rready_o(fp_s_rready),
    .grant_o(fp_grant), .busy_o(fp_busy), .err_o(fp_err)
  );

  // Packed as {m0_arready, m1_arready, s_arvalid, m0_rvalid, m1_rvalid, s_rready, busy, grant, err}
  logic [8:0] outVec;
  assign outVec = {m0_arready, m1_arready, s_arvalid, m0_rvalid, m1_rvalid, s_rready, busy, grant, err};

  // in = {rst, m0_arvalid, m1_arvalid, s_arready, s_rvalid, s_rlast, m0_rready, m1_rready}
  typedef struct {
    logic [7:0] in;
    logic [3:0] rid;
    logic [8:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] got[$];
  int          checks   = 0;
  int          failures = 0;

  function automatic vec_t mk(input logic [7:0] in, input logic [3:0] rid, input logic [8:0] exp);
    vec_t v;
    v.in  = in;
    v.rid = rid;
    v.exp = exp;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idleInputs();
    m0_arvalid = 1'b0;
    m1_arvalid = 1'b0;
    m0_rready  = 1'b0;
    m1_rready  = 1'b0;
    s_arready  = 1'b0;
    s_rvalid   = 1'b0;
    s_rlast    = 1'b0;
    s_rdata    = '0;
    s_rresp    = RESP_OKAY;
    s_rid      = '0;
  endtask

  task automatic doReset();
    idleInputs();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  task automatic setAr(input bit m, input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
    if (m) begin
      m1_araddr = a; m1_arid = id; m1_arlen = len; m1_arburst = INCR;
    end else begin
      m0_araddr = a; m0_arid = id; m0_arlen = len; m0_arburst = INCR;
    end
  endtask

  // Request from one master, then complete the ADDR phase; leaves the DUT entering DATA.
  task automatic startAr(input bit m);
    if (m) m1_arvalid = 1'b1; else m0_arvalid = 1'b1;
    cyc();
    m0_arvalid = 1'b0;
    m1_arvalid = 1'b0;
    s_arready  = 1'b1;
    cyc();
    s_arready  = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v, input logic [31:0] data);
    m0_arvalid = v.in[6];
    m1_arvalid = v.in[5];
    s_arready  = v.in[4];
    s_rvalid   = v.in[3];
    s_rlast    = v.in[2];
    m0_rready  = v.in[1];
    m1_rready  = v.in[0];
    s_rid      = v.rid;
    s_rdata    = data;
  endtask

  initial begin
    #200000;
    failures++;
    $display("[TB] FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    rst_i = 1'b0;
    setAr(1'b0, M0_ADDR, 4'd2, 8'd3);
    setAr(1'b1, M1_ADDR, 4'd5, 8'd1);
    doReset();
    checkOutput("reset s_araddr", s_araddr, 32'h0);
    checkOutput("reset s_arlen", s_arlen, 8'h0);

    // Single m0 burst of 4 beats, then a simultaneous request pair after reset.
    vecs.push_back(mk(8'b0100_0000, 4'd0, 9'b100_000_010));
    vecs.push_back(mk(8'b0000_0000, 4'd0, 9'b001_000_100));
    vecs.push_back(mk(8'b0001_0000, 4'd0, 9'b001_000_100));
    vecs.push_back(mk(8'b0000_1010, 4'd2, 9'b000_101_100));
    vecs.push_back(mk(8'b0000_1010, 4'd2, 9'b000_101_100));
    vecs.push_back(mk(8'b0000_1010, 4'd2, 9'b000_101_100));
    vecs.push_back(mk(8'b0000_1110, 4'd2, 9'b000_101_100));
    vecs.push_back(mk(8'b0000_0000, 4'd0, 9'b000_000_000));
    vecs.push_back(mk(8'b1110_0000, 4'd0, 9'b100_000_010));
    vecs.push_back(mk(8'b0011_0000, 4'd0, 9'b001_000_100));
    vecs.push_back(mk(8'b0010_1010, 4'd2, 9'b000_101_100));
    vecs.push_back(mk(8'b0010_1010, 4'd2, 9'b000_101_100));
    vecs.push_back(mk(8'b0010_1010, 4'd2, 9'b000_101_100));
    vecs.push_back(mk(8'b0010_1110, 4'd2, 9'b000_101_100));
    vecs.push_back(mk(8'b0010_0000, 4'd0, 9'b010_000_000));
    vecs.push_back(mk(8'b0001_0000, 4'd0, 9'b001_000_110));
    vecs.push_back(mk(8'b0000_1010, 4'd5, 9'b000_010_110));
    vecs.push_back(mk(8'b0000_1001, 4'd5, 9'b000_011_110));
    vecs.push_back(mk(8'b0000_1101, 4'd5, 9'b000_011_110));
    vecs.push_back(mk(8'b0000_0000, 4'd0, 9'b000_000_010));

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].in[7]) doReset();
      applyStimulus(vecs[i], 32'hD000_0000 + i);
      #1;
      checkOutput($sformatf("vec%0d outputs", i), outVec, vecs[i].exp);
      if (vecs[i].exp[6]) begin
        checkOutput($sformatf("vec%0d s_araddr", i), s_araddr, vecs[i].exp[1] ? M1_ADDR : M0_ADDR);
        checkOutput($sformatf("vec%0d s_arid", i), s_arid, vecs[i].exp[1] ? 4'd5 : 4'd2);
        checkOutput($sformatf("vec%0d s_arlen", i), s_arlen, vecs[i].exp[1] ? 8'd1 : 8'd3);
      end
      if (vecs[i].exp[5]) checkOutput($sformatf("vec%0d m0_rdata", i), m0_rdata, 32'hD000_0000 + i);
      if (vecs[i].exp[4]) checkOutput($sformatf("vec%0d m1_rdata", i), m1_rdata, 32'hD000_0000 + i);
      cyc();
    end

    // Both masters hammer single-beat bursts: fixed priority always picks m0, RR alternates.
    doReset();
    setAr(1'b0, M0_ADDR, 4'd2, 8'd0);
    setAr(1'b1, M1_ADDR, 4'd2, 8'd0);
    m0_arvalid = 1'b1;
    m1_arvalid = 1'b1;
    m0_rready  = 1'b1;
    m1_rready  = 1'b1;
    s_rid      = 4'd2;
    for (int k = 0; k < 4; k++) begin
      s_arready = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0;
      #1;
      checkOutput($sformatf("fp m0_arready b%0d", k), fp_m0_arready, 1'b1);
      checkOutput($sformatf("fp m1_arready b%0d", k), fp_m1_arready, 1'b0);
      checkOutput($sformatf("rr m1_arready b%0d", k), m1_arready, k % 2);
      cyc();
      s_arready = 1'b1;
      #1;
      checkOutput($sformatf("fp grant b%0d", k), fp_grant, 1'b0);
      cyc();
      s_arready = 1'b0; s_rvalid = 1'b1; s_rlast = 1'b1;
      #1;
      checkOutput($sformatf("fp m0_rvalid b%0d", k), fp_m0_rvalid, 1'b1);
      cyc();
    end
    idleInputs();

    // Early rlast on beat 2 of a len=3 burst, then a clean m1 burst.
    doReset();
    setAr(1'b0, M0_ADDR, 4'd2, 8'd3);
    setAr(1'b1, M1_ADDR, 4'd5, 8'd1);
    startAr(1'b0);
    s_rvalid = 1'b1; m0_rready = 1'b1; s_rid = 4'd2;
    cyc();
    cyc();
    #1;
    checkOutput("early-last err before", err, 1'b0);
    s_rlast = 1'b1;
    cyc();
    idleInputs();
    #1;
    checkOutput("early-last err set", err, 1'b1);
    checkOutput("early-last busy", busy, 1'b0);
    m1_arvalid = 1'b1;
    #1;
    checkOutput("early-last m1_arready", m1_arready, 1'b1);
    cyc();
    m1_arvalid = 1'b0; s_arready = 1'b1;
    #1;
    checkOutput("early-last s_arid m1", s_arid, 4'd5);
    cyc();
    s_arready = 1'b0; s_rvalid = 1'b1; m1_rready = 1'b1; s_rid = 4'd5;
    cyc();
    s_rlast = 1'b1;
    #1;
    checkOutput("m1 burst m1_rvalid", m1_rvalid, 1'b1);
    checkOutput("m1 burst m0_rvalid", m0_rvalid, 1'b0);
    cyc();
    idleInputs();
    #1;
    checkOutput("m1 burst busy", busy, 1'b0);
    checkOutput("err sticky", err, 1'b1);
    checkOutput("m1 burst grant", grant, 1'b1);

    // Master backpressure for five cycles mid-burst.
    doReset();
    setAr(1'b0, M0_ADDR, 4'd2, 8'd3);
    startAr(1'b0);
    begin
      int sIdx = 0;
      logic rr;
      for (int c = 0; c < 20 && sIdx < 4; c++) begin
        rr = !(c >= 1 && c <= 5);
        m0_rready = rr;
        s_rvalid  = 1'b1;
        s_rid     = 4'd2;
        s_rdata   = 32'hA500_0000 + sIdx;
        s_rlast   = (sIdx == 3);
        #1;
        checkOutput($sformatf("bp s_rready c%0d", c), s_rready, rr);
        if (m0_rvalid && m0_rready) got.push_back(m0_rdata);
        if (s_rvalid && s_rready) sIdx++;
        cyc();
      end
    end
    idleInputs();
    #1;
    checkOutput("bp beat count", got.size(), 4);
    for (int k = 0; k < got.size(); k++)
      checkOutput($sformatf("bp beat%0d data", k), got[k], 32'hA500_0000 + k);
    checkOutput("bp busy", busy, 1'b0);
    checkOutput("bp err", err, 1'b0);

    // Asynchronous reset in the middle of a len=7 burst.
    doReset();
    setAr(1'b0, M0_ADDR, 4'd2, 8'd7);
    startAr(1'b0);
    s_rvalid = 1'b1; m0_rready = 1'b1; s_rid = 4'd2;
    cyc();
    cyc();
    #1;
    checkOutput("midrst m0_rvalid before", m0_rvalid, 1'b1);
    rst_i = 1'b1;
    #1;
    checkOutput("midrst busy", busy, 1'b0);
    checkOutput("midrst m0_rvalid", m0_rvalid, 1'b0);
    checkOutput("midrst s_rready", s_rready, 1'b0);
    checkOutput("midrst grant", grant, 1'b1);
    checkOutput("midrst s_arvalid", s_arvalid, 1'b0);
    checkOutput("midrst s_arlen", s_arlen, 8'h0);
    idleInputs();
    cyc();
    rst_i = 1'b0;
    m0_arvalid = 1'b1; m1_arvalid = 1'b1;
    #1;
    checkOutput("midrst m0_arready", m0_arready, 1'b1);
    checkOutput("midrst m1_arready", m1_arready, 1'b0);
    cyc();
    idleInputs();

    // Stray s_rvalid in IDLE.
    doReset();
    s_rvalid = 1'b1;
    #1;
    checkOutput("stray s_rready", s_rready, 1'b0);
    cyc();
    s_rvalid = 1'b0;
    #1;
    checkOutput("stray err", err, 1'b1);

    // len=0 bursts: clean, missing rlast, wrong rid.
    doReset();
    setAr(1'b0, M0_ADDR, 4'd2, 8'd0);
    startAr(1'b0);
    s_rvalid = 1'b1; s_rlast = 1'b1; m0_rready = 1'b1; s_rid = 4'd2;
    cyc();
    idleInputs();
    #1;
    checkOutput("len0 busy", busy, 1'b0);
    checkOutput("len0 err", err, 1'b0);
    startAr(1'b0);
    s_rvalid = 1'b1; s_rlast = 1'b0; m0_rready = 1'b1; s_rid = 4'd2;
    cyc();
    #1;
    checkOutput("nolast err", err, 1'b1);
    checkOutput("nolast busy", busy, 1'b1);
    s_rlast = 1'b1;
    cyc();
    idleInputs();
    #1;
    checkOutput("nolast busy after", busy, 1'b0);
    doReset();
    startAr(1'b0);
    s_rvalid = 1'b1; s_rlast = 1'b1; m0_rready = 1'b1; s_rid = 4'd7;
    cyc();
    idleInputs();
    #1;
    checkOutput("badid err", err, 1'b1);

    // Maximum-length burst of 256 beats.
    doReset();
    setAr(1'b0, M0_ADDR, 4'd2, 8'd255);
    startAr(1'b0);
    s_rvalid = 1'b1; m0_rready = 1'b1; s_rid = 4'd2;
    for (int b = 0; b < 256; b++) begin
      s_rlast = (b == 255);
      cyc();
    end
    idleInputs();
    #1;
    checkOutput("len255 busy", busy, 1'b0);
    checkOutput("len255 err", err, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
